// File: rtl/sweep_scheduler_if.sv
// rtl/sweep_scheduler_if.sv - user-control, measurement/TX handshake and status bundle for the sweep scheduler
interface sweep_scheduler_if #(
    parameter int POS_W = 3
);
    logic             ligar;
    logic             parar;
    logic             silencio;
    logic             fim_medida;
    logic             fim_transmissao;
    logic             mensurar;
    logic             partida_serial;
    logic [POS_W-1:0] posicao;
    logic             fim_posicao;
    logic             timeout;
    logic [3:0]       db_estado;

    // Environment side: user controls and unit completion pulses in, sequencer outputs observed
    modport master (
        output ligar, parar, silencio, fim_medida, fim_transmissao,
        input  mensurar, partida_serial, posicao, fim_posicao, timeout, db_estado
    );

    // Scheduler side
    modport slave (
        input  ligar, parar, silencio, fim_medida, fim_transmissao,
        output mensurar, partida_serial, posicao, fim_posicao, timeout, db_estado
    );
endinterface

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - sonar sweep sequencer (settle, measure, optional TX, ping-pong advance); SWEEP_RETRY_EN adds one re-measure per position after a timeout
module sweep_scheduler #(
    parameter int N_POS          = 8,
    parameter int POS_W          = 3,
    parameter int SETTLE_CYCLES  = 25_000_000,
    parameter int TIMEOUT_CYCLES = 3_000_000
) (
    input  logic               clock,
    input  logic               reset,
    sweep_scheduler_if.slave   bus
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef enum logic [3:0] {
        S_INICIAL        = 4'd0,
        S_ESPERA_SERVO   = 4'd1,
        S_DISPARA        = 4'd2,
        S_AGUARDA_MEDIDA = 4'd3,
        S_TRANSMITE      = 4'd4,
        S_AGUARDA_TX     = 4'd5,
        S_PROXIMA        = 4'd6,
        S_TIMEOUT        = 4'd7
    } state_t;

    state_t           state_q, state_d;
    logic [POS_W-1:0] posicao_q, posicao_d;
    logic             dir_up_q, dir_up_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             mensurar_q, mensurar_d;
    logic             partida_q, partida_d;
    logic             fim_pos_q, fim_pos_d;
    logic             timeout_q, timeout_d;
`ifdef SWEEP_RETRY_EN
    logic             retry_q, retry_d;
`endif

    // Next-state, counter and position logic
    always_comb begin
        state_d   = state_q;
        posicao_d = posicao_q;
        dir_up_d  = dir_up_q;
        settle_d  = '0;
        tmo_d     = '0;
`ifdef SWEEP_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_INICIAL: begin
                if (bus.ligar && !bus.parar) begin
                    state_d = S_ESPERA_SERVO;
                end
            end
            S_ESPERA_SERVO: begin
                settle_d = settle_q + SET_W'(1);
                if (settle_q == SET_LAST) begin
                    state_d = S_DISPARA;
                end
            end
            S_DISPARA: begin
                state_d = S_AGUARDA_MEDIDA;
            end
            S_AGUARDA_MEDIDA: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A result arriving on the terminal cycle still counts as a result
                if (bus.fim_medida) begin
                    state_d = bus.silencio ? S_PROXIMA : S_TRANSMITE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_TIMEOUT: begin
`ifdef SWEEP_RETRY_EN
                if (!retry_q) begin
                    retry_d = 1'b1;
                    state_d = S_DISPARA;
                end else begin
                    state_d = S_PROXIMA;
                end
`else
                state_d = S_PROXIMA;
`endif
            end
            S_TRANSMITE: begin
                state_d = S_AGUARDA_TX;
            end
            S_AGUARDA_TX: begin
                if (bus.fim_transmissao) begin
                    state_d = S_PROXIMA;
                end
            end
            S_PROXIMA: begin
`ifdef SWEEP_RETRY_EN
                retry_d = 1'b0;
`endif
                // Ping-pong walk: turn around at either end without repeating it
                if (dir_up_q) begin
                    if (posicao_q == POS_LAST) begin
                        posicao_d = posicao_q - POS_ONE;
                        dir_up_d  = 1'b0;
                    end else begin
                        posicao_d = posicao_q + POS_ONE;
                    end
                end else begin
                    if (posicao_q == '0) begin
                        posicao_d = POS_ONE;
                        dir_up_d  = 1'b1;
                    end else begin
                        posicao_d = posicao_q - POS_ONE;
                    end
                end
                if (bus.parar || !bus.ligar) begin
                    state_d = S_INICIAL;
                end else begin
                    state_d = S_ESPERA_SERVO;
                end
            end
            default: begin
                state_d = S_INICIAL;
            end
        endcase
    end

    // Pulse outputs are registered from the state being entered, so they track the state register exactly
    always_comb begin
        mensurar_d = (state_d == S_DISPARA);
        partida_d  = (state_d == S_TRANSMITE);
        fim_pos_d  = (state_d == S_PROXIMA);
        timeout_d  = (state_d == S_TIMEOUT);
    end

    // State, counters, position and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_INICIAL;
            posicao_q  <= '0;
            dir_up_q   <= 1'b1;
            settle_q   <= '0;
            tmo_q      <= '0;
            mensurar_q <= 1'b0;
            partida_q  <= 1'b0;
            fim_pos_q  <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef SWEEP_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            posicao_q  <= posicao_d;
            dir_up_q   <= dir_up_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            mensurar_q <= mensurar_d;
            partida_q  <= partida_d;
            fim_pos_q  <= fim_pos_d;
            timeout_q  <= timeout_d;
`ifdef SWEEP_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    // Display code straight from the state register; any unused encoding shows F
    always_comb begin
        case (state_q)
            S_INICIAL, S_ESPERA_SERVO, S_DISPARA, S_AGUARDA_MEDIDA,
            S_TRANSMITE, S_AGUARDA_TX, S_PROXIMA, S_TIMEOUT: bus.db_estado = state_q;
            default:                                         bus.db_estado = 4'hF;
        endcase
    end

    assign bus.mensurar       = mensurar_q;
    assign bus.partida_serial = partida_q;
    assign bus.fim_posicao    = fim_pos_q;
    assign bus.timeout        = timeout_q;
    assign bus.posicao        = posicao_q;

endmodule
